// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator: alignment check, lane-shifted memory request,
// load extension and a watchdog that converts a stalled memory into an access fault.
module lsu_mem_initiator #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exception,
    output logic [3:0]  resp_exception_code,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [7:0]  wd;
    logic        illegal, misaligned, expire;
    logic [3:0]  strb_nxt;
    logic [31:0] wdata_nxt, lane, load_ext;

    always_comb begin
        illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_we && req_funct3[2]);
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        expire     = (wd == WD_LAST);
    end

    always_comb begin
        strb_nxt  = '0;
        wdata_nxt = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                strb_nxt  = 4'b0001 << req_addr[1:0];
                wdata_nxt = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                strb_nxt  = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{req_wdata[15:0]}};
            end
            default: begin
                strb_nxt  = 4'b1111;
                wdata_nxt = req_wdata;
            end
        endcase
        if (!req_we)
            strb_nxt = '0;
    end

    // Half-word offsets are always 0 or 2 here, so one shift serves both widths.
    always_comb begin
        lane     = mem_rdata >> {off_q, 3'b000};
        load_ext = mem_rdata;
        case (f3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'd0, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'd0, lane[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = (illegal || misaligned) ? RESP : REQ;
            REQ: begin
                if (mem_req_ready)
                    state_nxt = we_q ? RESP : WAIT;
                else if (expire)
                    state_nxt = RESP;
            end
            WAIT: if (mem_rvalid || expire) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state == IDLE);
        mem_req_valid = (state == REQ);
        resp_valid    = (state == RESP);
    end

    // Response fields are loaded only on entry to RESP and cleared while in it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q                <= 1'b0;
            f3_q                <= '0;
            off_q               <= '0;
            wd                  <= '0;
            mem_we              <= 1'b0;
            mem_addr            <= '0;
            mem_wstrb           <= '0;
            mem_wdata           <= '0;
            resp_rdata          <= '0;
            resp_exception      <= 1'b0;
            resp_exception_code <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[1:0];
                        wd        <= '0;
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wstrb <= strb_nxt;
                        mem_wdata <= wdata_nxt;
                        if (illegal) begin
                            resp_exception      <= 1'b1;
                            resp_exception_code <= 4'd2;
                        end else if (misaligned) begin
                            resp_exception      <= 1'b1;
                            resp_exception_code <= req_we ? 4'd6 : 4'd4;
                        end
                    end
                end
                REQ: begin
                    wd <= wd + 8'd1;
                    if (!mem_req_ready && expire) begin
                        resp_exception      <= 1'b1;
                        resp_exception_code <= we_q ? 4'd7 : 4'd5;
                    end
                end
                WAIT: begin
                    wd <= wd + 8'd1;
                    if (mem_rvalid) begin
                        resp_rdata <= load_ext;
                    end else if (expire) begin
                        resp_exception      <= 1'b1;
                        resp_exception_code <= we_q ? 4'd7 : 4'd5;
                    end
                end
                RESP: begin
                    resp_rdata          <= '0;
                    resp_exception      <= 1'b0;
                    resp_exception_code <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed self-checking bench for lsu_mem_initiator with a simple stall-configurable memory.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_exception;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_exception_code;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_exception(resp_exception), .resp_exception_code(resp_exception_code),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // memory behaviour knobs
    int rdy_stall = 0;
    int rv_delay  = 0;
    bit no_rv     = 0;

    // captured transaction results
    int          r_k;
    logic [31:0] r_data;
    logic        r_exc;
    logic [3:0]  r_code;
    logic        r_seen, r_we, r_mrv;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_strb;

    // Presents one request, accepts it at edge T and returns in the cycle after the response.
    task automatic run_txn(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        int  req_seen;
        int  wait_idx;
        bit  in_wait;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_k = -1; r_seen = 0; r_data = 'x; r_exc = 'x; r_code = 'x; r_mrv = 'x;
        r_we = 'x; r_addr = 'x; r_strb = 'x; r_wdata = 'x;
        req_seen = 0; wait_idx = 0; in_wait = 0;
        for (int k = 1; k <= 40; k++) begin
            mem_req_ready = 1'b0;
            mem_rvalid    = 1'b0;
            if (resp_valid) begin
                r_k = k; r_data = resp_rdata; r_exc = resp_exception;
                r_code = resp_exception_code; r_mrv = mem_req_valid;
                break;
            end
            if (mem_req_valid) begin
                if (!r_seen) begin
                    r_we = mem_we; r_addr = mem_addr; r_strb = mem_wstrb; r_wdata = mem_wdata;
                end
                r_seen = 1'b1;
                if (req_seen >= rdy_stall) begin
                    mem_req_ready = 1'b1;
                    if (!we) in_wait = 1'b1;
                end
                req_seen++;
            end else if (in_wait) begin
                if (!no_rv && wait_idx == rv_delay) mem_rvalid = 1'b1;
                wait_idx++;
            end
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        if (r_k > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_exception, resp_exception_code, mem_req_valid, mem_we, mem_wstrb}
            !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b",
                {req_ready, resp_valid, resp_exception, resp_exception_code, mem_req_valid, mem_we, mem_wstrb},
                {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0});
        end
        checks++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h expected all zero", resp_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b1;
    endtask

    task automatic test_store();
        logic [2:0]  f3  [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] ad  [3] = '{32'h0000_0102, 32'h0000_0002, 32'h0000_0008};
        logic [31:0] wd  [3] = '{32'h0000_00AB, 32'h5555_1234, 32'hDEAD_BEEF};
        logic [3:0]  es  [3] = '{4'b0100, 4'b1100, 4'b1111};
        logic [31:0] ew  [3] = '{32'hABAB_ABAB, 32'h1234_1234, 32'hDEAD_BEEF};
        logic [31:0] ea  [3] = '{32'h0000_0100, 32'h0000_0000, 32'h0000_0008};
        rdy_stall = 0; rv_delay = 0; no_rv = 0;
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b1, f3[i], ad[i], wd[i]);
            checks++;
            if (r_k !== 2 || r_exc !== 1'b0 || r_data !== 32'd0) begin
                errors++;
                $display("FAIL store_resp[%0d]: got k=%0d exc=%b data=%h expected k=2 exc=0 data=0",
                         i, r_k, r_exc, r_data);
            end
            checks++;
            if ({r_we, r_addr, r_strb, r_wdata} !== {1'b1, ea[i], es[i], ew[i]}) begin
                errors++;
                $display("FAIL store_mem[%0d]: got we=%b addr=%h strb=%b wdata=%h expected we=1 addr=%h strb=%b wdata=%h",
                         i, r_we, r_addr, r_strb, r_wdata, ea[i], es[i], ew[i]);
            end
        end
    endtask

    task automatic test_load();
        logic [2:0]  f3 [7] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b010, 3'b100, 3'b000};
        logic [31:0] ad [7] = '{32'h0, 32'h1, 32'h2, 32'h2, 32'h0, 32'h1, 32'h1003};
        logic [31:0] ex [7] = '{32'h0000_007F, 32'hFFFF_FFF0, 32'h0000_8001, 32'hFFFF_8001,
                                32'h8001_F07F, 32'h0000_00F0, 32'hFFFF_FF80};
        logic [31:0] ea [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1000};
        mem_rdata = 32'h8001_F07F;
        rdy_stall = 0; rv_delay = 0; no_rv = 0;
        for (int i = 0; i < 7; i++) begin
            run_txn(1'b0, f3[i], ad[i], 32'hFFFF_FFFF);
            checks++;
            if (r_k !== 3 || r_exc !== 1'b0 || r_data !== ex[i]) begin
                errors++;
                $display("FAIL load[%0d]: got k=%0d exc=%b data=%h expected k=3 exc=0 data=%h",
                         i, r_k, r_exc, r_data, ex[i]);
            end
            checks++;
            if ({r_we, r_strb, r_addr} !== {1'b0, 4'b0000, ea[i]}) begin
                errors++;
                $display("FAIL load_mem[%0d]: got we=%b strb=%b addr=%h expected we=0 strb=0000 addr=%h",
                         i, r_we, r_strb, r_addr, ea[i]);
            end
        end
    endtask

    task automatic test_exceptions();
        logic        we [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3 [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b001, 3'b110};
        logic [31:0] ad [6] = '{32'h6, 32'h3, 32'h0, 32'h0, 32'h1, 32'h0};
        logic [3:0]  ec [6] = '{4'd4, 4'd6, 4'd2, 4'd2, 4'd4, 4'd2};
        for (int i = 0; i < 6; i++) begin
            run_txn(we[i], f3[i], ad[i], 32'h1234_5678);
            checks++;
            if (r_k !== 1 || r_exc !== 1'b1 || r_code !== ec[i] || r_seen !== 1'b0 || r_data !== 32'd0) begin
                errors++;
                $display("FAIL exception[%0d]: got k=%0d exc=%b code=%0d memreq=%b data=%h expected k=1 exc=1 code=%0d memreq=0 data=0",
                         i, r_k, r_exc, r_code, r_seen, r_data, ec[i]);
            end
        end
    endtask

    task automatic test_stall_timeout();
        mem_rdata = 32'h8001_F07F;
        rdy_stall = 3; rv_delay = 4; no_rv = 0;
        run_txn(1'b0, 3'b010, 32'h0, 32'h0);
        checks++;
        if (r_k !== 10 || r_exc !== 1'b0 || r_data !== 32'h8001_F07F) begin
            errors++;
            $display("FAIL stall_load: got k=%0d exc=%b data=%h expected k=10 exc=0 data=8001f07f", r_k, r_exc, r_data);
        end
        no_rv = 1;
        run_txn(1'b0, 3'b010, 32'h0, 32'h0);
        checks++;
        if (r_k !== 17 || r_exc !== 1'b1 || r_code !== 4'd5 || r_data !== 32'd0) begin
            errors++;
            $display("FAIL load_timeout: got k=%0d exc=%b code=%0d data=%h expected k=17 exc=1 code=5 data=0",
                     r_k, r_exc, r_code, r_data);
        end
        rdy_stall = 0; rv_delay = 14; no_rv = 0;
        run_txn(1'b0, 3'b010, 32'h0, 32'h0);
        checks++;
        if (r_k !== 17 || r_exc !== 1'b0 || r_data !== 32'h8001_F07F) begin
            errors++;
            $display("FAIL rvalid_at_expiry: got k=%0d exc=%b data=%h expected k=17 exc=0 data=8001f07f",
                     r_k, r_exc, r_data);
        end
        rdy_stall = 100;
        run_txn(1'b1, 3'b010, 32'h0000_0040, 32'h0BAD_F00D);
        checks++;
        if (r_k !== 17 || r_exc !== 1'b1 || r_code !== 4'd7 || r_mrv !== 1'b0) begin
            errors++;
            $display("FAIL store_timeout: got k=%0d exc=%b code=%0d memreq=%b expected k=17 exc=1 code=7 memreq=0",
                     r_k, r_exc, r_code, r_mrv);
        end
        rdy_stall = 0; rv_delay = 0; no_rv = 0;
    endtask

    task automatic test_back_to_back();
        mem_rdata = 32'h8001_F07F;
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b0, 3'b000, 32'(i), 32'h0);
            checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got ready=%b resp=%b expected ready=1 resp=0", i, req_ready, resp_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        mem_rdata = 32'h8001_F07F;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_abort: got resp=%b ready=%b expected resp=0 ready=1", resp_valid, req_ready);
        end
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_rvalid: got resp=%b ready=%b memreq=%b expected resp=0 ready=1 memreq=0",
                     resp_valid, req_ready, mem_req_valid);
        end
        run_txn(1'b0, 3'b010, 32'h0, 32'h0);
        checks++;
        if (r_k !== 3 || r_exc !== 1'b0 || r_data !== 32'h8001_F07F) begin
            errors++;
            $display("FAIL post_reset_load: got k=%0d exc=%b data=%h expected k=3 exc=0 data=8001f07f",
                     r_k, r_exc, r_data);
        end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        test_reset();
        test_store();
        test_load();
        test_exceptions();
        test_stall_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
